// File: rtl/uart_pkg.sv
// uart_pkg: state encodings and constants shared by the uart_transceiver slice.
// Build option UART_PARITY_EN adds a PARITY state to both the TX and RX FSMs.
package uart_pkg;
   localparam int DATA_BITS = 8;
   localparam int BIT_W     = $clog2(DATA_BITS);
   localparam int MIN_DIV   = 2;

   typedef enum logic [2:0] {
      TX_IDLE,
      TX_START,
      TX_DATA,
`ifdef UART_PARITY_EN
      TX_PARITY,
`endif
      TX_STOP
   } tx_state_t;

   typedef enum logic [2:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
`ifdef UART_PARITY_EN
      RX_PARITY,
`endif
      RX_STOP
   } rx_state_t;
endpackage

// File: rtl/uart_if.sv
// uart_if: host-side byte handshake and divisor configuration for uart_transceiver.
// master = host fabric, slave = transceiver.
interface uart_if #(
   parameter int DIV_W = 13
) ();
   logic [DIV_W-1:0] uart_ctrl_tx;
   logic [DIV_W-1:0] uart_ctrl_rx;
   logic             tx_start;
   logic [7:0]       tx_data;
   logic             tx_done;
   logic             rx_int;
   logic [7:0]       rx_data;

   modport master (
      output uart_ctrl_tx, uart_ctrl_rx, tx_start, tx_data,
      input  tx_done, rx_int, rx_data
   );

   modport slave (
      input  uart_ctrl_tx, uart_ctrl_rx, tx_start, tx_data,
      output tx_done, rx_int, rx_data
   );
endinterface

// File: rtl/uart_bit_timer.sv
// uart_bit_timer: bit-period down-counter with terminal-count flag.
// A load clamps and latches the divisor for the whole frame; the first period may be a
// half period (RX start-bit centering). After that it reloads a full period at every tc.
module uart_bit_timer
   import uart_pkg::*;
#(
   parameter int DIV_W = 13
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic             load_half,
   input  logic             run,
   input  logic [DIV_W-1:0] div,
   output logic             tc
);
   logic [DIV_W-1:0] div_clamped;
   logic [DIV_W-1:0] first_len;
   logic [DIV_W-1:0] period;
   logic [DIV_W-1:0] cnt;

   assign div_clamped = (div < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : div;
   assign first_len   = load_half ? (div_clamped >> 1) : div_clamped;
   assign tc          = (cnt == '0);

   // Latch the frame's period on load, then count down and auto-reload on terminal count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         period <= DIV_W'(MIN_DIV);
         cnt    <= '0;
      end else if (load) begin
         period <= div_clamped;
         cnt    <= first_len - DIV_W'(1);
      end else if (run) begin
         if (tc) cnt <= period - DIV_W'(1);
         else    cnt <= cnt - DIV_W'(1);
      end
   end
endmodule

// File: rtl/uart_transceiver.sv
// uart_transceiver: full-duplex UART, 8 data bits LSB first, one stop bit.
// TX and RX are independent paths, each with its own bit timer and FSM.
// Build option UART_PARITY_EN: even-parity bit after data bit 7 on both paths.
//
// state     | meaning
// TX_IDLE   | line high, waiting for tx_start
// TX_START  | driving start bit (0)
// TX_DATA   | driving data bits, LSB first
// TX_PARITY | driving even parity (UART_PARITY_EN only)
// TX_STOP   | driving stop bit (1); tx_done pulses as it ends
// RX_IDLE   | waiting for a 1->0 on the synchronized line
// RX_START  | half-period check that the start bit is real
// RX_DATA   | sampling data bits mid-bit
// RX_PARITY | sampling parity bit (UART_PARITY_EN only)
// RX_STOP   | sampling stop bit; deliver byte or drop on framing error
module uart_transceiver
   import uart_pkg::*;
#(
   parameter int DIV_W = 13
) (
   input  logic  clk,
   input  logic  rst_n,
   input  logic  rs232_rx,
   output logic  rs232_tx,
   uart_if.slave host
);
   tx_state_t            tx_state, tx_state_nxt;
   logic [DATA_BITS-1:0] tx_sh, tx_sh_nxt;
   logic [BIT_W-1:0]     tx_bit, tx_bit_nxt;
   logic                 tx_line, tx_line_nxt;
   logic                 tx_done_q, tx_done_nxt;
   logic                 tx_load, tx_run, tx_tc;

   rx_state_t            rx_state, rx_state_nxt;
   logic [DATA_BITS-1:0] rx_sh, rx_sh_nxt;
   logic [BIT_W-1:0]     rx_bit, rx_bit_nxt;
   logic [DATA_BITS-1:0] rx_data_q, rx_data_nxt;
   logic                 rx_int_q, rx_int_nxt;
   logic                 rx_load, rx_run, rx_tc;
   logic                 rx_s1, rx_s2, rx_prev, rx_fall;
`ifdef UART_PARITY_EN
   logic                 tx_par, tx_par_nxt;
   logic                 rx_par_ok, rx_par_ok_nxt;
`endif

   assign rs232_tx     = tx_line;
   assign host.tx_done = tx_done_q;
   assign host.rx_int  = rx_int_q;
   assign host.rx_data = rx_data_q;
   assign tx_run       = (tx_state != TX_IDLE);
   assign rx_run       = (rx_state != RX_IDLE);
   assign rx_fall      = rx_prev & ~rx_s2;

   uart_bit_timer #(.DIV_W(DIV_W)) u_tx_timer (
      .clk(clk), .rst_n(rst_n), .load(tx_load), .load_half(1'b0),
      .run(tx_run), .div(host.uart_ctrl_tx), .tc(tx_tc)
   );

   uart_bit_timer #(.DIV_W(DIV_W)) u_rx_timer (
      .clk(clk), .rst_n(rst_n), .load(rx_load), .load_half(1'b1),
      .run(rx_run), .div(host.uart_ctrl_rx), .tc(rx_tc)
   );

   // TX next-state: the line value is computed one cycle ahead so rs232_tx comes straight from a flop.
   always_comb begin
      tx_state_nxt = tx_state;
      tx_sh_nxt    = tx_sh;
      tx_bit_nxt   = tx_bit;
      tx_line_nxt  = tx_line;
      tx_done_nxt  = 1'b0;
      tx_load      = 1'b0;
`ifdef UART_PARITY_EN
      tx_par_nxt   = tx_par;
`endif
      case (tx_state)
         TX_IDLE: begin
            tx_line_nxt = 1'b1;
            if (host.tx_start) begin
               tx_load      = 1'b1;
               tx_sh_nxt    = host.tx_data;
               tx_bit_nxt   = '0;
               tx_line_nxt  = 1'b0;
               tx_state_nxt = TX_START;
`ifdef UART_PARITY_EN
               tx_par_nxt   = ^host.tx_data;
`endif
            end
         end
         TX_START: if (tx_tc) begin
            tx_line_nxt  = tx_sh[0];
            tx_state_nxt = TX_DATA;
         end
         TX_DATA: if (tx_tc) begin
            if (tx_bit == BIT_W'(DATA_BITS-1)) begin
`ifdef UART_PARITY_EN
               tx_line_nxt  = tx_par;
               tx_state_nxt = TX_PARITY;
`else
               tx_line_nxt  = 1'b1;
               tx_state_nxt = TX_STOP;
`endif
            end else begin
               tx_sh_nxt   = tx_sh >> 1;
               tx_line_nxt = tx_sh[1];
               tx_bit_nxt  = tx_bit + BIT_W'(1);
            end
         end
`ifdef UART_PARITY_EN
         TX_PARITY: if (tx_tc) begin
            tx_line_nxt  = 1'b1;
            tx_state_nxt = TX_STOP;
         end
`endif
         TX_STOP: if (tx_tc) begin
            tx_state_nxt = TX_IDLE;
            tx_done_nxt  = 1'b1;
         end
         default: tx_state_nxt = TX_IDLE;
      endcase
   end

   // TX state register; reset forces the line back to idle-high immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_state  <= TX_IDLE;
         tx_sh     <= '0;
         tx_bit    <= '0;
         tx_line   <= 1'b1;
         tx_done_q <= 1'b0;
`ifdef UART_PARITY_EN
         tx_par    <= 1'b0;
`endif
      end else begin
         tx_state  <= tx_state_nxt;
         tx_sh     <= tx_sh_nxt;
         tx_bit    <= tx_bit_nxt;
         tx_line   <= tx_line_nxt;
         tx_done_q <= tx_done_nxt;
`ifdef UART_PARITY_EN
         tx_par    <= tx_par_nxt;
`endif
      end
   end

   // Two-flop synchronizer on the async serial input, plus a delayed copy for edge detection.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_s1   <= 1'b1;
         rx_s2   <= 1'b1;
         rx_prev <= 1'b1;
      end else begin
         rx_s1   <= rs232_rx;
         rx_s2   <= rx_s1;
         rx_prev <= rx_s2;
      end
   end

   // RX next-state. After a framing error IDLE needs a fresh 1->0, so a line stuck low never re-arms.
   always_comb begin
      rx_state_nxt  = rx_state;
      rx_sh_nxt     = rx_sh;
      rx_bit_nxt    = rx_bit;
      rx_data_nxt   = rx_data_q;
      rx_int_nxt    = 1'b0;
      rx_load       = 1'b0;
`ifdef UART_PARITY_EN
      rx_par_ok_nxt = rx_par_ok;
`endif
      case (rx_state)
         RX_IDLE: if (rx_fall) begin
            rx_load      = 1'b1;
            rx_bit_nxt   = '0;
            rx_state_nxt = RX_START;
         end
         RX_START: if (rx_tc) begin
            rx_state_nxt = rx_s2 ? RX_IDLE : RX_DATA;
         end
         RX_DATA: if (rx_tc) begin
            rx_sh_nxt = {rx_s2, rx_sh[DATA_BITS-1:1]};
            if (rx_bit == BIT_W'(DATA_BITS-1)) begin
`ifdef UART_PARITY_EN
               rx_state_nxt = RX_PARITY;
`else
               rx_state_nxt = RX_STOP;
`endif
            end else begin
               rx_bit_nxt = rx_bit + BIT_W'(1);
            end
         end
`ifdef UART_PARITY_EN
         RX_PARITY: if (rx_tc) begin
            rx_par_ok_nxt = (rx_s2 == ^rx_sh);
            rx_state_nxt  = RX_STOP;
         end
`endif
         RX_STOP: if (rx_tc) begin
            rx_state_nxt = RX_IDLE;
`ifdef UART_PARITY_EN
            if (rx_s2 && rx_par_ok) begin
`else
            if (rx_s2) begin
`endif
               rx_data_nxt = rx_sh;
               rx_int_nxt  = 1'b1;
            end
         end
         default: rx_state_nxt = RX_IDLE;
      endcase
   end

   // RX state register and delivered-byte holding register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_state  <= RX_IDLE;
         rx_sh     <= '0;
         rx_bit    <= '0;
         rx_data_q <= '0;
         rx_int_q  <= 1'b0;
`ifdef UART_PARITY_EN
         rx_par_ok <= 1'b0;
`endif
      end else begin
         rx_state  <= rx_state_nxt;
         rx_sh     <= rx_sh_nxt;
         rx_bit    <= rx_bit_nxt;
         rx_data_q <= rx_data_nxt;
         rx_int_q  <= rx_int_nxt;
`ifdef UART_PARITY_EN
         rx_par_ok <= rx_par_ok_nxt;
`endif
      end
   end
endmodule

// File: tb/tb_uart_transceiver.sv
// tb_uart_transceiver: self-checking bench for uart_transceiver (8N1, or 8E1 with UART_PARITY_EN).
module tb_uart_transceiver;
   localparam int DIV_W = 13;
`ifdef UART_PARITY_EN
   localparam int NBITS = 11;
`else
   localparam int NBITS = 10;
`endif

   logic clk = 1'b0;
   logic rst_n;
   logic rx_drv;
   logic loop_en;
   logic tx_line;
   logic rx_line;
   int   total = 0;
   int   bad   = 0;
   logic [7:0] exp_q[$];
   logic [7:0] last_rx;

   uart_if #(.DIV_W(DIV_W)) hif ();

   uart_transceiver #(.DIV_W(DIV_W)) dut (
      .clk(clk), .rst_n(rst_n), .rs232_rx(rx_line), .rs232_tx(tx_line), .host(hif)
   );

   assign rx_line = loop_en ? tx_line : rx_drv;

   always #5 clk = ~clk;

   function automatic logic [10:0] build_frame(input logic [7:0] b, input logic stop_bit);
`ifdef UART_PARITY_EN
      return {stop_bit, ^b, b, 1'b0};
`else
      return {1'b1, stop_bit, b, 1'b0};
`endif
   endfunction

   task automatic start_tx(input logic [7:0] b);
      @(negedge clk);
      hif.tx_start = 1'b1;
      hif.tx_data  = b;
      @(posedge clk);
      #1;
      hif.tx_start = 1'b0;
      hif.tx_data  = ~b;
   endtask

   // Called just after the accepting edge; checks every sample of every bit, then the tx_done slot.
   task automatic watch_frame(input logic [7:0] b, input int n, input string tag, input int inject_at);
      logic exp_bits[$];
      logic want;
      int   errs;
      exp_bits.push_back(1'b0);
      for (int i = 0; i < 8; i++) exp_bits.push_back(b[i]);
`ifdef UART_PARITY_EN
      exp_bits.push_back(^b);
`endif
      exp_bits.push_back(1'b1);
      for (int bi = 0; bi < NBITS; bi++) begin
         want = exp_bits.pop_front();
         errs = 0;
         for (int s = 0; s < n; s++) begin
            @(negedge clk);
            if (tx_line !== want || hif.tx_done !== 1'b0) errs++;
            if (inject_at >= 0 && bi*n+s == inject_at) begin
               hif.tx_start = 1'b1;
               hif.tx_data  = ~b;
            end else if (inject_at >= 0 && bi*n+s == inject_at+1) begin
               hif.tx_start = 1'b0;
            end
         end
         total++;
         if (errs != 0) begin
            bad++;
            $display("FAIL %s bit%0d: %0d of %0d samples wrong, line=%b done=%b, want line=%b done=0",
                     tag, bi, errs, n, tx_line, hif.tx_done, want);
         end
      end
      @(negedge clk);
      total++;
      if (hif.tx_done !== 1'b1) begin
         bad++;
         $display("FAIL %s done_at_%0d: tx_done=%b want 1", tag, NBITS*n, hif.tx_done);
      end
   endtask

   task automatic check_idle(input int cycles, input string tag);
      int errs = 0;
      repeat (cycles) begin
         @(negedge clk);
         if (tx_line !== 1'b1 || hif.tx_done !== 1'b0) errs++;
      end
      total++;
      if (errs != 0) begin
         bad++;
         $display("FAIL %s idle: %0d of %0d cycles not idle, want line=1 done=0", tag, errs, cycles);
      end
   endtask

   task automatic count_rx(input int cycles, output int pulses, output logic [7:0] got);
      pulses = 0;
      got    = 8'hxx;
      repeat (cycles) begin
         @(negedge clk);
         if (hif.rx_int === 1'b1) begin
            pulses++;
            got = hif.rx_data;
         end
      end
   endtask

   task automatic drive_rx(input logic [10:0] frame, input int n);
      for (int i = 0; i < NBITS; i++) begin
         rx_drv = frame[i];
         repeat (n) @(negedge clk);
      end
      rx_drv = 1'b1;
   endtask

   task automatic test_reset();
      int   pulses = 0;
      logic high   = 1'b1;
      rst_n = 1'b0;
      loop_en = 1'b0;
      rx_drv = 1'b1;
      hif.tx_start = 1'b0;
      hif.tx_data = 8'h00;
      hif.uart_ctrl_tx = 13'd16;
      hif.uart_ctrl_rx = 13'd16;
      repeat (3) @(negedge clk);
      total++; if (tx_line !== 1'b1) begin bad++; $display("FAIL reset_tx: got %b want 1", tx_line); end
      total++; if (hif.tx_done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", hif.tx_done); end
      total++; if (hif.rx_int !== 1'b0) begin bad++; $display("FAIL reset_int: got %b want 0", hif.rx_int); end
      total++; if (hif.rx_data !== 8'h00) begin bad++; $display("FAIL reset_data: got %h want 00", hif.rx_data); end
      rst_n = 1'b1;
      repeat (20) begin
         @(negedge clk);
         if (tx_line !== 1'b1) high = 1'b0;
         if (hif.tx_done !== 1'b0 || hif.rx_int !== 1'b0) pulses++;
      end
      total++;
      if (!high || pulses != 0) begin
         bad++;
         $display("FAIL post_reset: line_high=%b pulses=%0d want 1 and 0", high, pulses);
      end
      last_rx = 8'h00;
   endtask

   task automatic test_tx_timing();
      hif.uart_ctrl_tx = 13'd16;
      start_tx(8'h21);
      watch_frame(8'h21, 16, "tx21", -1);
      check_idle(5, "tx21");
      hif.uart_ctrl_tx = 13'd0;
      start_tx(8'hC5);
      watch_frame(8'hC5, 2, "div0", -1);
      hif.uart_ctrl_tx = 13'd1;
      start_tx(8'h3A);
      watch_frame(8'h3A, 2, "div1", -1);
      check_idle(5, "div1");
   endtask

   task automatic test_busy();
      hif.uart_ctrl_tx = 13'd8;
      start_tx(8'hA5);
      watch_frame(8'hA5, 8, "busy", 20);
      check_idle(30, "busy_noqueue");
   endtask

   task automatic test_back_to_back();
      hif.uart_ctrl_tx = 13'd8;
      @(negedge clk);
      hif.tx_start = 1'b1;
      hif.tx_data  = 8'h3C;
      @(posedge clk);
      #1;
      hif.tx_data  = 8'hC3;
      watch_frame(8'h3C, 8, "b2b0", -1);
      @(posedge clk);
      #1;
      hif.tx_start = 1'b0;
      hif.tx_data  = 8'h00;
      watch_frame(8'hC3, 8, "b2b1", -1);
      check_idle(20, "b2b");
   endtask

   task automatic test_loopback();
      logic [7:0] seq [6] = '{8'h33, 8'h55, 8'h33, 8'h56, 8'h38, 8'h45};
      logic [7:0] got, want;
      int pulses;
      loop_en = 1'b1;
      hif.uart_ctrl_tx = 13'd16;
      hif.uart_ctrl_rx = 13'd16;
      for (int rep = 0; rep < 2; rep++) begin
         for (int i = 0; i < 6; i++) begin
            exp_q.push_back(seq[i]);
            fork
               start_tx(seq[i]);
               count_rx(12*16, pulses, got);
            join
            want = exp_q.pop_front();
            total++;
            if (pulses != 1 || got !== want) begin
               bad++;
               $display("FAIL loop%0d_%0d: pulses=%0d data=%h want 1 pulse data=%h", rep, i, pulses, got, want);
            end
            last_rx = want;
         end
      end
      loop_en = 1'b0;
   endtask

   task automatic test_rx_robust();
      logic [7:0] got, want;
      int pulses;
      rx_drv = 1'b1;
      hif.uart_ctrl_rx = 13'd16;
      repeat (5) @(negedge clk);
      fork
         begin rx_drv = 1'b0; repeat (3) @(negedge clk); rx_drv = 1'b1; end
         count_rx(60, pulses, got);
      join
      total++;
      if (pulses != 0) begin bad++; $display("FAIL glitch: pulses=%0d want 0", pulses); end

      fork
         drive_rx(build_frame(8'h99, 1'b0), 16);
         count_rx(14*16, pulses, got);
      join
      total++;
      if (pulses != 0) begin bad++; $display("FAIL framing_int: pulses=%0d want 0", pulses); end
      total++;
      if (hif.rx_data !== last_rx) begin bad++; $display("FAIL framing_hold: rx_data=%h want %h", hif.rx_data, last_rx); end

`ifdef UART_PARITY_EN
      fork
         drive_rx(build_frame(8'h71, 1'b1) ^ 11'h200, 16);
         count_rx(14*16, pulses, got);
      join
      total++;
      if (pulses != 0 || hif.rx_data !== last_rx) begin
         bad++;
         $display("FAIL parity_err: pulses=%0d rx_data=%h want 0 and %h", pulses, hif.rx_data, last_rx);
      end
`endif

      exp_q.push_back(8'h6B);
      fork
         drive_rx(build_frame(8'h6B, 1'b1), 16);
         count_rx(13*16, pulses, got);
      join
      want = exp_q.pop_front();
      total++;
      if (pulses != 1 || got !== want) begin
         bad++;
         $display("FAIL after_err: pulses=%0d data=%h want 1 pulse data=%h", pulses, got, want);
      end
      total++;
      if (hif.rx_data !== want) begin bad++; $display("FAIL rx_hold: rx_data=%h want %h", hif.rx_data, want); end
      last_rx = want;
   endtask

   task automatic test_midreset();
      hif.uart_ctrl_tx = 13'd8;
      start_tx(8'h52);
      repeat (36) @(negedge clk);
      total++;
      if (tx_line !== 1'b0) begin bad++; $display("FAIL pre_reset_bit3: line=%b want 0", tx_line); end
      #2;
      rst_n = 1'b0;
      #1;
      total++;
      if (tx_line !== 1'b1 || hif.tx_done !== 1'b0) begin
         bad++;
         $display("FAIL midreset_async: line=%b done=%b want 1 and 0", tx_line, hif.tx_done);
      end
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      last_rx = 8'h00;
      check_idle(100, "midreset");
      start_tx(8'h3D);
      watch_frame(8'h3D, 8, "post_reset", -1);
   endtask

   initial begin
      test_reset();
      test_tx_timing();
      test_busy();
      test_back_to_back();
      test_loopback();
      test_rx_robust();
      test_midreset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
